// File: rtl/sample_rate_scheduler_if.sv
// Handshake bundle between the sample-rate scheduler (master) and the
// stimulus/DUT side (slave): write request/accept, result valid, read strobe.
interface sample_rate_scheduler_if;
    logic wr_valid;
    logic wr_ready;
    logic res_valid;
    logic rd_strobe;

    modport master (
        output wr_valid,
        output rd_strobe,
        input  wr_ready,
        input  res_valid
    );

    modport slave (
        input  wr_valid,
        input  rd_strobe,
        output wr_ready,
        output res_valid
    );
endinterface

// File: rtl/sample_rate_scheduler.sv
// Paces one write / wait-for-result / read exchange with the DUT per sample tick;
// ticks come from a fractional phase accumulator stepping SAMPLE_FREQ against DUT_CLK_FREQ.
module sample_rate_scheduler #(
    parameter int unsigned DUT_CLK_FREQ = 100_000_000,
    parameter int unsigned SAMPLE_FREQ  = 1_000_000,
    parameter int unsigned ACC_W        = 32,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_W-1:0]        num_samples,
    sample_rate_scheduler_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        sample_idx,
    output logic                    overrun,
    output logic                    timeout_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        WRITE     = 3'd2,
        WAIT_RES  = 3'd3,
        READ      = 3'd4
    } state_t;

    // One bit of headroom so acc + SAMPLE_FREQ never overflows before the compare.
    localparam logic [ACC_W:0] INC       = (ACC_W+1)'(SAMPLE_FREQ);
    localparam logic [ACC_W:0] MODULUS   = (ACC_W+1)'(DUT_CLK_FREQ);
    localparam logic [7:0]     WDOG_LAST = 8'(TIMEOUT - 1);

    state_t            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W:0]    sum;
    logic              tick;
    logic [7:0]        wdog_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  idx_d;
    logic              wr_valid_q;
    logic              rd_strobe_q;
    logic              done_q;
    logic              overrun_q;
    logic              timeout_q;

    assign busy = (state_q != IDLE);

    always_comb begin
        sum   = {1'b0, acc_q} + INC;
        tick  = busy && (sum >= MODULUS);
        acc_d = tick ? ACC_W'(sum - MODULUS) : ACC_W'(sum);
        idx_d = idx_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            wdog_q      <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            wr_valid_q  <= 1'b0;
            rd_strobe_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            rd_strobe_q <= 1'b0;
            done_q      <= 1'b0;
            if (busy) begin
                acc_q <= acc_d;
            end
            if (abort) begin
                state_q    <= IDLE;
                wr_valid_q <= 1'b0;
            end else begin
                // A tick outside WAIT_TICK is dropped; the exit edge of WAIT_TICK consumes its own tick.
                if (tick && (state_q != WAIT_TICK)) begin
                    overrun_q <= 1'b1;
                end
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (num_samples == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q   <= WAIT_TICK;
                                num_q     <= num_samples;
                                idx_q     <= '0;
                                acc_q     <= '0;
                                overrun_q <= 1'b0;
                                timeout_q <= 1'b0;
                            end
                        end
                    end
                    WAIT_TICK: begin
                        if (tick) begin
                            state_q    <= WRITE;
                            wr_valid_q <= 1'b1;
                        end
                    end
                    WRITE: begin
                        if (bus.wr_ready) begin
                            state_q    <= WAIT_RES;
                            wr_valid_q <= 1'b0;
                            wdog_q     <= '0;
                        end
                    end
                    WAIT_RES: begin
                        if (bus.res_valid) begin
                            state_q     <= READ;
                            rd_strobe_q <= 1'b1;
                            idx_q       <= idx_d;
                            done_q      <= (idx_d == num_q);
                        end else if (wdog_q == WDOG_LAST) begin
                            state_q   <= IDLE;
                            timeout_q <= 1'b1;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end
                    READ: begin
                        state_q <= (idx_q == num_q) ? IDLE : WAIT_TICK;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.wr_valid  = wr_valid_q;
    assign bus.rd_strobe = rd_strobe_q;
    assign done          = done_q;
    assign sample_idx    = idx_q;
    assign overrun       = overrun_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_sample_rate_scheduler.sv
// Bench for sample_rate_scheduler: a 100M/1M instance driven by an emulated DUT
// and a 10M/3M instance whose write timing is predicted from the tick arithmetic.
module tb_sample_rate_scheduler;
    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic             start1, abort1, busy1, done1, ovr1, to1;
    logic [CNT_W-1:0] num1, idx1;
    logic             start2, abort2, busy2, done2, ovr2, to2;
    logic [CNT_W-1:0] num2, idx2;

    sample_rate_scheduler_if bus1 ();
    sample_rate_scheduler_if bus2 ();

    sample_rate_scheduler dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .num_samples(num1),
        .bus(bus1), .busy(busy1), .done(done1), .sample_idx(idx1),
        .overrun(ovr1), .timeout_err(to1)
    );

    sample_rate_scheduler #(.DUT_CLK_FREQ(10_000_000), .SAMPLE_FREQ(3_000_000)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .num_samples(num2),
        .bus(bus2), .busy(busy2), .done(done2), .sample_idx(idx2),
        .overrun(ovr2), .timeout_err(to2)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc;                    // clock edges since the edge that accepted start
    bit prev_wr1, prev_wr2;
    bit wr_chk;
    int exp_wr_q[$];
    int exp_wr2_q[$];
    int exp_idx_q[$];
    int cur_num;
    int res_dly;                // result latency of the emulated DUT; <= 0 means never
    int res_cnt;
    int nrd, ndone, nwr, nhs, nrd2, ndone2;
    int hs_cyc;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; monitor outputs at the falling edge and emulate the DUT result.
    task automatic cyc1();
        bit hs;
        int exp_i;
        hs = bus1.wr_valid && bus1.wr_ready;
        @(negedge clk);
        cyc++;
        bus1.res_valid = 1'b0;
        if (bus1.wr_valid && !prev_wr1) begin
            nwr++;
            if (wr_chk) begin
                if (exp_wr_q.size() > 0) check_eq("wr_edge", cyc, exp_wr_q.pop_front());
                else check_eq("wr_extra", cyc, -1);
            end
        end
        prev_wr1 = bus1.wr_valid;
        if (bus2.wr_valid && !prev_wr2) begin
            if (exp_wr2_q.size() > 0) check_eq("wr2_edge", cyc, exp_wr2_q.pop_front());
            else check_eq("wr2_extra", cyc, -1);
        end
        prev_wr2 = bus2.wr_valid;
        if (bus1.rd_strobe) begin
            nrd++;
            if (exp_idx_q.size() > 0) begin
                exp_i = exp_idx_q.pop_front();
                check_eq("rd_idx", idx1, exp_i);
                check_eq("rd_done", done1, (exp_i == cur_num) ? 1 : 0);
            end else begin
                check_eq("rd_extra", nrd, 0);
            end
        end
        if (done1) ndone++;
        if (bus2.rd_strobe) nrd2++;
        if (done2) ndone2++;
        if (hs) begin
            hs_cyc = cyc - 1;
            nhs++;
            exp_idx_q.push_back(nhs);
            if (res_dly > 0) res_cnt = res_dly;
        end
        if (res_cnt > 0) begin
            res_cnt--;
            if (res_cnt == 0) bus1.res_valid = 1'b1;
        end
    endtask

    task automatic start_run(input int n);
        num1    = CNT_W'(n);
        cur_num = n;
        start1  = 1'b1;
        nrd = 0; ndone = 0; nwr = 0; nhs = 0; res_cnt = 0;
        exp_idx_q.delete();
        cyc = -1;
        cyc1();
        start1 = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int k;
        k = 0;
        while (busy1 && k < budget) begin
            cyc1();
            k++;
        end
        if (busy1) check_eq({tag, "_idle_timeout"}, busy1, 0);
    endtask

    function automatic bit tick_at(input int e);
        return ((3 * (e + 1)) / 10) != ((3 * e) / 10);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "bench time limit");
    end

    initial begin
        int free_e, got, last_e, e, k;
        bit exp_ovr;
        rst_n = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; num1 = '0;
        start2 = 1'b0; abort2 = 1'b0; num2 = '0;
        bus1.wr_ready = 1'b1; bus1.res_valid = 1'b0;
        bus2.wr_ready = 1'b1; bus2.res_valid = 1'b1;
        res_dly = 3; res_cnt = 0; wr_chk = 1'b0; cyc = 0;
        prev_wr1 = 1'b0; prev_wr2 = 1'b0; nrd2 = 0; ndone2 = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_wr_valid", bus1.wr_valid, 0);
        check_eq("rst_busy", busy1, 0);
        check_eq("rst_done", done1, 0);
        check_eq("rst_idx", idx1, 0);
        check_eq("rst_flags", {ovr1, to1, bus1.rd_strobe}, 0);
        rst_n = 1'b1;
        repeat (3) cyc1();

        // 1: nominal run, one write every 100 edges
        wr_chk = 1'b1;
        exp_wr_q = '{100, 200, 300, 400};
        start_run(4);
        run_until_idle(1000, "t1");
        wr_chk = 1'b0;
        check_eq("t1_nrd", nrd, 4);
        check_eq("t1_ndone", ndone, 1);
        check_eq("t1_idx", idx1, 4);
        check_eq("t1_overrun", ovr1, 0);
        check_eq("t1_timeout", to1, 0);
        check_eq("t1_wr_left", exp_wr_q.size(), 0);

        // 2: stalled write on sample 1 drops a tick
        bus1.wr_ready = 1'b0;
        start_run(3);
        while (cyc < 250) cyc1();
        bus1.wr_ready = 1'b1;
        run_until_idle(1000, "t2");
        check_eq("t2_overrun", ovr1, 1);
        check_eq("t2_nrd", nrd, 3);
        check_eq("t2_ndone", ndone, 1);
        check_eq("t2_idx", idx1, 3);
        check_eq("t2_timeout", to1, 0);

        // 3: result never arrives
        res_dly = -1;
        start_run(2);
        run_until_idle(1000, "t3");
        check_eq("t3_timeout", to1, 1);
        check_eq("t3_idle_edge", cyc, 356);
        check_eq("t3_hs_edge", hs_cyc, 100);
        check_eq("t3_ndone", ndone, 0);
        check_eq("t3_nrd", nrd, 0);
        res_dly = 3;

        // 4: zero samples
        start_run(0);
        check_eq("t4_done", done1, 1);
        check_eq("t4_busy", busy1, 0);
        cyc1();
        check_eq("t4_done_pulse", done1, 0);
        repeat (150) cyc1();
        check_eq("t4_nwr", nwr, 0);
        check_eq("t4_ndone", ndone, 1);

        // 5: abort while sample 2 is stuck in WRITE, then restart
        bus1.wr_ready = 1'b1;
        start_run(4);
        while (nrd < 1 && cyc < 400) cyc1();
        check_eq("t5_first_rd", nrd, 1);
        bus1.wr_ready = 1'b0;
        while (cyc < 320) cyc1();
        check_eq("t5_in_write", bus1.wr_valid, 1);
        check_eq("t5_ovr_pre", ovr1, 1);
        abort1 = 1'b1;
        cyc1();
        abort1 = 1'b0;
        check_eq("t5_wr_off", bus1.wr_valid, 0);
        check_eq("t5_busy", busy1, 0);
        check_eq("t5_idx", idx1, 1);
        check_eq("t5_ovr_kept", ovr1, 1);
        check_eq("t5_ndone", ndone, 0);
        bus1.wr_ready = 1'b1;
        start_run(1);
        check_eq("t5_re_idx", idx1, 0);
        check_eq("t5_re_ovr", ovr1, 0);
        check_eq("t5_re_busy", busy1, 1);
        run_until_idle(1000, "t5");
        check_eq("t5_re_done_idx", idx1, 1);
        check_eq("t5_re_ndone", ndone, 1);

        // 6a: asynchronous reset while waiting for sample 2's result
        start_run(2);
        while (nrd < 1 && cyc < 400) cyc1();
        res_dly = -1;
        while (cyc < 205) cyc1();
        check_eq("t6_pre_idx", idx1, 1);
        check_eq("t6_pre_busy", busy1, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_busy", busy1, 0);
        check_eq("t6_rst_idx", idx1, 0);
        check_eq("t6_rst_outs", {bus1.wr_valid, bus1.rd_strobe, done1, ovr1, to1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        res_dly = 3;
        repeat (2) cyc1();

        // 6b: 3 MHz from 10 MHz; result always ready, so writes follow only undropped ticks
        free_e = 0; got = 0; last_e = 0; e = 0; exp_ovr = 1'b0;
        while (got < 4) begin
            if (tick_at(e)) begin
                if (e >= free_e) begin
                    exp_wr2_q.push_back(e + 1);
                    free_e = e + 4;
                    last_e = e;
                    got++;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            e++;
        end
        for (int j = last_e + 1; j <= last_e + 3; j++) if (tick_at(j)) exp_ovr = 1'b1;
        num2 = CNT_W'(4);
        nrd2 = 0; ndone2 = 0;
        start2 = 1'b1;
        cyc = -1;
        cyc1();
        start2 = 1'b0;
        k = 0;
        while (busy2 && k < 200) begin
            cyc1();
            k++;
        end
        check_eq("t6_busy2", busy2, 0);
        check_eq("t6_wr2_left", exp_wr2_q.size(), 0);
        check_eq("t6_ovr2", ovr2, exp_ovr);
        check_eq("t6_idx2", idx2, 4);
        check_eq("t6_nrd2", nrd2, 4);
        check_eq("t6_ndone2", ndone2, 1);
        check_eq("t6_to2", to2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
